// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the 16-bit ALU datapath.
// Latches one instruction, decodes it, and walks the datapath through
// read / execute / write-back using Moore-style strobes.
//
// Handshake: the sequencer is idle and ready exactly when w=1 (state WAIT).
// A start is accepted on any rising edge where w=1 and s=1. The instruction
// register loads `in` on an edge where w=1 and load=1. `load` is ignored
// while busy. When s and load are both high in WAIT, the instruction
// loaded on that edge is the one executed.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_EXEC      = 3'd5,
    S_WRITE_C   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // IR field views
  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_mov_imm, is_mov_sh, is_alu, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_sh  = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);

  // Immediate is a plain function of IR, always visible to the datapath.
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

  // State and instruction register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR only accepts a new word while idle.
  always_comb begin
    ir_d = ir_q;
    if (state_q == S_WAIT && load) ir_d = in;
  end

  // Next-state and Moore outputs from state register and IR.
  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                            state_d = S_WRITE_IMM;
        else if (is_mov_sh || (is_alu && op == 2'b11)) state_d = S_GET_B;
        else if (is_alu)                           state_d = S_GET_A;
        else begin
          illegal = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WRITE_IMM: begin
        write    = 1'b1;
        writenum = rn;
        vsel     = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        if (is_mov_sh) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = op;
        end
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_C;
        end
      end
      S_WRITE_C: begin
        write    = 1'b1;
        writenum = rd;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with hand-computed expectations.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in = 16'h0000;
  logic        w, illegal, write, loada, loadb, loadc, loads, asel, vsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Strobe bundle: {write, loada, loadb, loadc, loads, illegal}
  logic [5:0] strb;
  assign strb = {write, loada, loadb, loadc, loads, illegal};

  alu_sequencer dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .vsel(vsel), .shift(shift),
    .ALUop(ALUop), .sximm8(sximm8)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Driver: load instr and pulse s; returns at the negedge of cycle 1 (DECODE).
  task automatic issue(input logic [15:0] instr);
    @(negedge clk);
    in = instr; load = 1'b1; s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; s = 1'b0; in = 16'h0000;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (w !== 1'b1 || strb !== 6'b0 || readnum !== 3'd0 || writenum !== 3'd0 ||
        shift !== 2'b00 || ALUop !== 2'b00 || asel !== 1'b0 || vsel !== 1'b0 ||
        sximm8 !== 16'h0000)
      $display("FAIL reset_state: w=%b strb=%b rn=%0d wn=%0d sh=%b op=%b asel=%b vsel=%b imm=%h, need w=1 all else 0",
               w, strb, readnum, writenum, shift, ALUop, asel, vsel, sximm8);
    else pass_cnt++;
    reset = 1'b0;
    issue(16'hD007);
    total_cnt++;
    if (w !== 1'b0 || strb !== 6'b0)
      $display("FAIL mov7_decode: w=%b strb=%b, need w=0 strb=000000", w, strb);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (strb !== 6'b100000 || writenum !== 3'd0 || vsel !== 1'b1 || sximm8 !== 16'h0007 || w !== 1'b0)
      $display("FAIL mov7_write: strb=%b wn=%0d vsel=%b imm=%h w=%b, need 100000 0 1 0007 0",
               strb, writenum, vsel, sximm8, w);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (w !== 1'b1 || strb !== 6'b0)
      $display("FAIL mov7_done: w=%b strb=%b, need w=1 strb=000000", w, strb);
    else pass_cnt++;
  endtask

  task automatic test_mov_neg;
    issue(16'hD1FE);
    @(negedge clk);
    total_cnt++;
    if (strb !== 6'b100000 || writenum !== 3'd1 || vsel !== 1'b1 || sximm8 !== 16'hFFFE)
      $display("FAIL mov_neg_write: strb=%b wn=%0d vsel=%b imm=%h, need 100000 1 1 fffe",
               strb, writenum, vsel, sximm8);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // ADD R2,R1,R0 LSL#1 with a load pulse during GET_B that must be ignored.
  task automatic test_add_lockout;
    issue(16'hA148);
    @(negedge clk); // cycle 2
    total_cnt++;
    if (strb !== 6'b010000 || readnum !== 3'd1 || w !== 1'b0)
      $display("FAIL add_get_a: strb=%b rn=%0d w=%b, need 010000 1 0", strb, readnum, w);
    else pass_cnt++;
    @(negedge clk); // cycle 3
    total_cnt++;
    if (strb !== 6'b001000 || readnum !== 3'd0)
      $display("FAIL add_get_b: strb=%b rn=%0d, need 001000 0", strb, readnum);
    else pass_cnt++;
    in = 16'hFFFF; load = 1'b1;
    @(negedge clk); // cycle 4
    load = 1'b0; in = 16'h0000;
    total_cnt++;
    if (strb !== 6'b000100 || shift !== 2'b01 || ALUop !== 2'b00 || asel !== 1'b0)
      $display("FAIL add_exec: strb=%b sh=%b op=%b asel=%b, need 000100 01 00 0",
               strb, shift, ALUop, asel);
    else pass_cnt++;
    @(negedge clk); // cycle 5
    total_cnt++;
    if (strb !== 6'b100000 || writenum !== 3'd2 || vsel !== 1'b0 || shift !== 2'b00)
      $display("FAIL add_write: strb=%b wn=%0d vsel=%b sh=%b, need 100000 2 0 00",
               strb, writenum, vsel, shift);
    else pass_cnt++;
    @(negedge clk); // cycle 6
    total_cnt++;
    if (w !== 1'b1 || sximm8 !== 16'h0048)
      $display("FAIL add_done_ir_kept: w=%b imm=%h, need w=1 imm=0048", w, sximm8);
    else pass_cnt++;
  endtask

  task automatic test_cmp;
    logic saw_write;
    saw_write = 1'b0;
    issue(16'hA801);
    saw_write |= write;
    @(negedge clk); saw_write |= write; // cycle 2
    total_cnt++;
    if (strb !== 6'b010000 || readnum !== 3'd0)
      $display("FAIL cmp_get_a: strb=%b rn=%0d, need 010000 0", strb, readnum);
    else pass_cnt++;
    @(negedge clk); saw_write |= write; // cycle 3
    total_cnt++;
    if (strb !== 6'b001000 || readnum !== 3'd1)
      $display("FAIL cmp_get_b: strb=%b rn=%0d, need 001000 1", strb, readnum);
    else pass_cnt++;
    @(negedge clk); saw_write |= write; // cycle 4
    total_cnt++;
    if (strb !== 6'b000010 || ALUop !== 2'b01 || asel !== 1'b0)
      $display("FAIL cmp_exec: strb=%b op=%b asel=%b, need 000010 01 0", strb, ALUop, asel);
    else pass_cnt++;
    @(negedge clk); saw_write |= write; // cycle 5
    total_cnt++;
    if (w !== 1'b1 || saw_write !== 1'b0)
      $display("FAIL cmp_done: w=%b saw_write=%b, need w=1 saw_write=0", w, saw_write);
    else pass_cnt++;
  endtask

  // MOV R3,R4 LSR (0xC074) then MVN R5,R6 (0xB8A6).
  task automatic test_mov_shift_mvn;
    issue(16'hC074);
    @(negedge clk); // cycle 2
    total_cnt++;
    if (strb !== 6'b001000 || readnum !== 3'd4)
      $display("FAIL movsh_get_b: strb=%b rn=%0d, need 001000 4", strb, readnum);
    else pass_cnt++;
    @(negedge clk); // cycle 3
    total_cnt++;
    if (strb !== 6'b000100 || shift !== 2'b10 || asel !== 1'b1 || ALUop !== 2'b00)
      $display("FAIL movsh_exec: strb=%b sh=%b asel=%b op=%b, need 000100 10 1 00",
               strb, shift, asel, ALUop);
    else pass_cnt++;
    @(negedge clk); // cycle 4
    total_cnt++;
    if (strb !== 6'b100000 || writenum !== 3'd3 || vsel !== 1'b0)
      $display("FAIL movsh_write: strb=%b wn=%0d vsel=%b, need 100000 3 0", strb, writenum, vsel);
    else pass_cnt++;
    @(negedge clk); // cycle 5
    total_cnt++;
    if (w !== 1'b1)
      $display("FAIL movsh_done: w=%b, need 1", w);
    else pass_cnt++;
    issue(16'hB8A6);
    @(negedge clk); // cycle 2
    total_cnt++;
    if (strb !== 6'b001000 || readnum !== 3'd6)
      $display("FAIL mvn_get_b: strb=%b rn=%0d, need 001000 6", strb, readnum);
    else pass_cnt++;
    @(negedge clk); // cycle 3
    total_cnt++;
    if (strb !== 6'b000100 || ALUop !== 2'b11 || asel !== 1'b0 || shift !== 2'b00)
      $display("FAIL mvn_exec: strb=%b op=%b asel=%b sh=%b, need 000100 11 0 00",
               strb, ALUop, asel, shift);
    else pass_cnt++;
    @(negedge clk); // cycle 4
    total_cnt++;
    if (strb !== 6'b100000 || writenum !== 3'd5)
      $display("FAIL mvn_write: strb=%b wn=%0d, need 100000 5", strb, writenum);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_illegal;
    issue(16'h0000);
    total_cnt++;
    if (illegal !== 1'b1 || w !== 1'b0 || strb !== 6'b000001)
      $display("FAIL illegal_pulse: illegal=%b w=%b strb=%b, need 1 0 000001", illegal, w, strb);
    else pass_cnt++;
    @(negedge clk); // cycle 2
    total_cnt++;
    if (w !== 1'b1 || strb !== 6'b0)
      $display("FAIL illegal_done: w=%b strb=%b, need w=1 strb=000000", w, strb);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic saw_write;
    saw_write = 1'b0;
    issue(16'hA148);
    @(negedge clk); // cycle 2 GET_A
    @(negedge clk); // cycle 3 GET_B
    #1 reset = 1'b1;
    #1;
    total_cnt++;
    if (w !== 1'b1 || strb !== 6'b0 || readnum !== 3'd0 || sximm8 !== 16'h0000)
      $display("FAIL reset_async: w=%b strb=%b rn=%0d imm=%h, need 1 000000 0 0000",
               w, strb, readnum, sximm8);
    else pass_cnt++;
    @(negedge clk); saw_write |= write;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk); saw_write |= write;
    end
    total_cnt++;
    if (saw_write !== 1'b0 || w !== 1'b1)
      $display("FAIL reset_no_write: saw_write=%b w=%b, need 0 1", saw_write, w);
    else pass_cnt++;
    issue(16'hD007);
    @(negedge clk);
    total_cnt++;
    if (strb !== 6'b100000 || writenum !== 3'd0 || sximm8 !== 16'h0007)
      $display("FAIL reset_recover: strb=%b wn=%0d imm=%h, need 100000 0 0007", strb, writenum, sximm8);
    else pass_cnt++;
    @(negedge clk);
  endtask

  // s held high: WAIT lasts a single cycle between instructions.
  task automatic test_back_to_back;
    @(negedge clk);
    in = 16'hD1FE; load = 1'b1; s = 1'b1;
    @(posedge clk);
    @(negedge clk); // cycle 1
    load = 1'b0; in = 16'h0000;
    @(negedge clk); // cycle 2
    total_cnt++;
    if (strb !== 6'b100000 || writenum !== 3'd1)
      $display("FAIL b2b_first_write: strb=%b wn=%0d, need 100000 1", strb, writenum);
    else pass_cnt++;
    @(negedge clk); // cycle 3 WAIT
    total_cnt++;
    if (w !== 1'b1)
      $display("FAIL b2b_wait: w=%b, need 1", w);
    else pass_cnt++;
    @(negedge clk); // cycle 4 DECODE
    total_cnt++;
    if (w !== 1'b0 || strb !== 6'b0)
      $display("FAIL b2b_restart: w=%b strb=%b, need 0 000000", w, strb);
    else pass_cnt++;
    s = 1'b0;
    @(negedge clk); // cycle 5
    total_cnt++;
    if (strb !== 6'b100000 || writenum !== 3'd1 || sximm8 !== 16'hFFFE)
      $display("FAIL b2b_second_write: strb=%b wn=%0d imm=%h, need 100000 1 fffe", strb, writenum, sximm8);
    else pass_cnt++;
    @(negedge clk); // cycle 6
    total_cnt++;
    if (w !== 1'b1)
      $display("FAIL b2b_done: w=%b, need 1", w);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_mov_neg;
    test_add_lockout;
    test_cmp;
    test_mov_shift_mvn;
    test_illegal;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
